// File: rtl/alu_result_stage.sv
// Result buffer behind the 4-bit ALU: captures result, opcode and status flags,
// queues them in a small FIFO with valid/ready on both sides, counts deliveries.
module alu_result_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_res,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_op,
  output logic [WIDTH-1:0] out_res,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [3:0]       r_op_mem   [DEPTH];
  logic [WIDTH-1:0] r_res_mem  [DEPTH];
  logic [3:0]       r_flag_mem [DEPTH];

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic [CNT_W-1:0] r_done_cnt;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_flags;

  // Handshake status comes only from stored occupancy, never from out_ready.
  assign w_in_ready  = (r_occ < OCC_FULL);
  assign w_out_valid = (r_occ != '0);
  assign w_push      = in_valid & w_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  // {carry, negative, zero, parity}; carry is meaningful only for arithmetic ops.
  always_comb begin
    w_flags    = '0;
    w_flags[3] = in_cout & in_op[3];
    w_flags[2] = in_res[WIDTH-1];
    w_flags[1] = ~|in_res;
    w_flags[0] = ^in_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_op_mem[i]   <= '0;
        r_res_mem[i]  <= '0;
        r_flag_mem[i] <= '0;
      end
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_done_cnt <= '0;
    end else begin
      if (w_push) begin
        r_op_mem[r_wptr]   <= in_op;
        r_res_mem[r_wptr]  <= in_res;
        r_flag_mem[r_wptr] <= w_flags;
        r_wptr             <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr     <= r_rptr + PTR_W'(1);
        r_done_cnt <= r_done_cnt + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_op    = w_out_valid ? r_op_mem[r_rptr]   : '0;
  assign out_res   = w_out_valid ? r_res_mem[r_rptr]  : '0;
  assign out_flags = w_out_valid ? r_flag_mem[r_rptr] : '0;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: driver queues expected entries on accept,
// monitor pops and compares on every delivered entry.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [3:0] in_res;
  logic       in_cout;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_op;
  logic [3:0] out_res;
  logic [3:0] out_flags;
  logic [7:0] done_cnt;

  int total = 0;
  int bad   = 0;
  int npop  = 0;
  int cyc   = 0;
  logic [11:0] sb[$];

  alu_result_stage #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_res(in_res), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_res(out_res), .out_flags(out_flags),
    .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] model_flags(input logic [3:0] op, input logic [3:0] res,
                                             input logic cout);
    logic [3:0] f;
    f[3] = cout && op[3];
    f[2] = res[3];
    f[1] = (res == 4'd0);
    f[0] = res[0] ^ res[1] ^ res[2] ^ res[3];
    return f;
  endfunction

  // Monitor: every delivered entry must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      npop++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got op=%0h res=%0h flags=%0h expected none",
                 out_op, out_res, out_flags);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        chk("out_entry", {20'd0, out_op, out_res, out_flags}, {20'd0, e});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge with in_valid still high.
  task automatic send(input logic [3:0] op, input logic [3:0] res, input logic cout,
                      input logic [3:0] exp_flags);
    int n;
    in_op = op; in_res = res; in_cout = cout; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    sb.push_back({op, res, exp_flags});
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_res = '0; in_cout = 1'b0; out_ready = 1'b0;
    do_reset();

    // Reset / idle
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_done_cnt", done_cnt, 0);
    @(posedge clk); #1;

    // Single logic push, cout ignored, held while stalled
    send(4'h2, 4'h0, 1'b1, 4'b0010);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_res", out_res, 4'h0);
      chk("hold_flags", out_flags, 4'b0010);
      chk("hold_op", out_op, 4'h2);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_after_1", done_cnt, 1);
    chk("empty_after_1", out_valid, 0);

    // Arithmetic flags, no same-cycle pass-through
    @(posedge clk); #1;
    in_op = 4'h8; in_res = 4'b1011; in_cout = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("no_passthru_valid", out_valid, 0);
    chk("no_passthru_res", out_res, 0);
    @(posedge clk);
    sb.push_back({4'h8, 4'b1011, 4'b1101});
    #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_after_2", done_cnt, 2);

    // Fill and backpressure
    @(posedge clk); #1 out_ready = 1'b0;
    send(4'h1, 4'h1, 1'b0, 4'b0001);
    send(4'h2, 4'h2, 1'b0, 4'b0001);
    in_op = 4'h3; in_res = 4'h3; in_cout = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      chk("full_head", out_res, 4'h1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_in_ready", in_ready, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("drained", out_valid, 0);
    @(posedge clk); #1;
    send(4'h3, 4'h3, 1'b0, 4'b0000);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("done_after_fill", done_cnt, 5);
    chk("sb_empty_fill", sb.size(), 0);

    // Streaming 300 entries through a fresh reset
    do_reset();
    npop = 0;
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op, res;
      logic cout;
      op = 4'(i); res = 4'(i * 7 + 3); cout = (i % 3) == 0;
      send(op, res, cout, model_flags(op, res, cout));
    end
    in_valid = 1'b0;
    chk("stream_cycles", cyc - c0, 300);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stream_done_cnt", done_cnt, 44);
    chk("stream_npop", npop, 300);
    chk("stream_sb_empty", sb.size(), 0);

    // Reset with entries in flight
    @(posedge clk); #1 out_ready = 1'b0;
    send(4'h9, 4'hF, 1'b1, 4'b1100);
    send(4'h0, 4'h6, 1'b0, 4'b0000);
    rst = 1'b1; in_valid = 1'b1; in_op = 4'h5; in_res = 4'h5; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_done", done_cnt, 0);
    chk("mid_rst_res", out_res, 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    send(4'hA, 4'h8, 1'b1, 4'b1101);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_done", done_cnt, 1);
    chk("post_rst_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
